mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, is the number of consecutive data grants allowed while a fetch is pending.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  global run enable; 0 blocks new grants.
REQ-005 if_req  input  1  instruction fetch request, level, held until if_ack.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 if_rdata  output  32  fetched word, valid only while if_ack=1, else 0.
REQ-009 d_req  input  1  data request, level, held until d_ack.
REQ-010 d_we  input  1  1=store, 0=load.
REQ-011 d_be  input  4  store byte enables.
REQ-012 d_addr  input  32  data byte address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_ack  output  1  one-cycle data completion pulse, for loads and stores.
REQ-015 d_rdata  output  32  load word, valid only while d_ack=1 on a load, else 0.
REQ-016 mem_addr  output  30  word address to unified memory (byte address [31:2]).
REQ-017 mem_we  output  1  memory write strobe.
REQ-018 mem_be  output  4  memory byte enables.
REQ-019 mem_wdata  output  32  memory write data.
REQ-020 mem_rdata  input  32  memory read data; 1-cycle synchronous read.
REQ-021 busy  output  1  high whenever state is not IDLE.

Function
REQ-022 FSM states: IDLE, ACCESS, RESP.
REQ-023 IDLE: if ena=1 and any request is pending, register the winner's address, we, be and wdata, then go to ACCESS; otherwise stay in IDLE.
REQ-024 ACCESS: drive the registered mem_* outputs for exactly one cycle; mem_we=1 only for a data store; always go to RESP regardless of ena.
REQ-025 RESP: pulse the winner's ack; pass mem_rdata to the winner's rdata on a fetch or load; mem_we=0.
REQ-026 RESP next state: with ena=1 and a pending request from the non-acked requester, arbitrate and go directly to ACCESS; otherwise go to IDLE.
REQ-027 The requester acked in RESP is excluded from that cycle's arbitration, because its req is still high.
REQ-028 Arbitration: data wins over fetch, unless the starvation counter equals STARVE_LIMIT and if_req=1, in which case fetch wins.
REQ-029 Starvation counter: increments on each data grant made while if_req=1; clears on any fetch grant; saturates at STARVE_LIMIT.
REQ-030 Latency: request seen in IDLE -> ack exactly 2 cycles later; back-to-back transactions complete one every 2 cycles.
REQ-031 Address bits [1:0] are ignored; fetches and loads drive mem_be=4'b1111, and stores drive d_be unchanged.
REQ-032 Requests or inputs changing while a transaction is in flight do not affect it; the captured values are used.
REQ-033 When neither state is ACCESS, mem_addr, mem_be and mem_wdata hold 0.

Reset
REQ-034 rst_n=0 immediately forces IDLE, all outputs to 0 and the counter to 0.
REQ-035 A transaction interrupted by reset is never acked, and the requester re-issues it.

Structure
REQ-036 The state enum, STARVE_LIMIT default and word width live in the shared package mips_pkg.
REQ-037 Single module, no sub-module; the priority pick is a local function.

Verification
REQ-038 Fetch only: if_req=1, if_addr=0x0000_0040 -> mem_addr=0x10 in ACCESS; if_ack=1 two cycles later with if_rdata=mem_rdata.
REQ-039 Simultaneous requests: if_req=1 and d_req=1 (load at 0x100) -> d_ack first, if_ack 2 cycles later, with no idle cycle between.
REQ-040 Starvation: d_req held high with if_req=1 -> 4 consecutive d_acks, then if_ack, then data resumes.
REQ-041 Store: d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF -> mem_we=1 for exactly one cycle with mem_be=0011, then d_ack=1 and d_rdata=0.
REQ-042 ena=0 raised during ACCESS -> the in-flight ack still occurs, no new grant is made, busy falls; ena=1 resumes arbitration.
REQ-043 rst_n=0 asserted in ACCESS -> all outputs 0 immediately, no ack ever for that transaction, and IDLE after release.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg -- shared definitions for the unified-memory arbiter.
//
// Contents:
//   WORD_W            data/address word width
//   STARVE_LIMIT_DEF  default number of consecutive data grants tolerated while
//                     an instruction fetch is waiting
//   arb_state_e       arbiter FSM states
//   xact_t            one captured memory transaction
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int WORD_W           = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    // Everything the memory needs for one access, frozen at grant time so
    // requesters may change their inputs while the access is in flight.
    typedef struct packed {
        logic              is_data;  // 1 = data port won, 0 = fetch port won
        logic [WORD_W-3:0] addr;     // word address (byte address [31:2])
        logic              we;
        logic [3:0]        be;
        logic [WORD_W-1:0] wdata;
    } xact_t;

endpackage

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter -- arbitrates an instruction-fetch port and a data port onto one
// unified, 1-cycle synchronous-read memory.
//
// Each transaction takes IDLE/RESP -> ACCESS -> RESP: the captured request is
// driven to memory for one cycle, and the read data is returned with a
// one-cycle ack on the next. Data has priority, but a fetch that has watched
// STARVE_LIMIT data grants go by wins the next arbitration.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ena                     run enable; 0 blocks new grants
//   if_req/if_addr          fetch request (level, held until if_ack)
//   if_ack/if_rdata         fetch completion pulse and fetched word
//   d_req/d_we/d_be/        data request (level, held until d_ack)
//   d_addr/d_wdata
//   d_ack/d_rdata           data completion pulse and load word
//   mem_addr/mem_we/        memory request, nonzero only in ACCESS
//   mem_be/mem_wdata
//   mem_rdata               memory read data, valid the cycle after ACCESS
//   busy                    FSM not idle
// -----------------------------------------------------------------------------
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic              if_ack,
    output logic [WORD_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] d_rdata,
    output logic [WORD_W-3:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    // Priority pick: data wins unless a waiting fetch has been starved.
    function automatic logic pick_data(input logic if_ok, input logic d_ok,
                                       input logic starved);
        return d_ok && !(starved && if_ok);
    endfunction

    arb_state_e       state_q, state_d;
    xact_t            xact_q, xact_d;
    logic [CNT_W-1:0] starve_q, starve_d;

    logic if_ok;
    logic d_ok;
    logic grant_data;
    logic in_access;
    logic in_resp;

    // Byte-offset bits are meaningless to a word-addressed memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d  = state_q;
        xact_d   = xact_q;
        starve_d = starve_q;

        // In RESP the acked requester still holds its req for the transaction
        // being completed, so it must not be granted again this cycle.
        if_ok      = if_req && !(state_q == ST_RESP && !xact_q.is_data);
        d_ok       = d_req  && !(state_q == ST_RESP &&  xact_q.is_data);
        grant_data = pick_data(if_ok, d_ok, starve_q == CNT_MAX);

        case (state_q)
            ST_ACCESS: state_d = ST_RESP;
            default: begin
                // IDLE and RESP share the arbitration; RESP falls back to IDLE.
                if (ena && (if_ok || d_ok)) begin
                    state_d = ST_ACCESS;
                    if (grant_data) begin
                        xact_d = '{is_data: 1'b1,
                                   addr:    d_addr[WORD_W-1:2],
                                   we:      d_we,
                                   be:      d_we ? d_be : 4'b1111,
                                   wdata:   d_wdata};
                        if (if_ok && starve_q != CNT_MAX) begin
                            starve_d = starve_q + CNT_W'(1);
                        end
                    end else begin
                        xact_d = '{is_data: 1'b0,
                                   addr:    if_addr[WORD_W-1:2],
                                   we:      1'b0,
                                   be:      4'b1111,
                                   wdata:   '0};
                        starve_d = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            xact_q   <= '0;
            starve_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            xact_q   <= xact_d;
            starve_q <= starve_d;
        end
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset clears them immediately.
    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);

    assign mem_addr  = in_access ? xact_q.addr  : '0;
    assign mem_we    = in_access && xact_q.we;
    assign mem_be    = in_access ? xact_q.be    : '0;
    assign mem_wdata = in_access ? xact_q.wdata : '0;

    assign if_ack    = in_resp && !xact_q.is_data;
    assign d_ack     = in_resp &&  xact_q.is_data;
    assign if_rdata  = if_ack ? mem_rdata : '0;
    assign d_rdata   = (d_ack && !xact_q.we) ? mem_rdata : '0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter -- self-checking bench for mem_arbiter.
//
// A synchronous memory stand-in returns a fixed hash of the address presented
// during ACCESS. Single transactions come from a vector table, the multi-cycle
// corners (simultaneous requests, starvation, enable drop, reset mid-access)
// are hand sequences, and a random phase is compared every cycle against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [29:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_hash(input logic [29:0] a);
        return {a, 2'b11} ^ 32'hC3A5_5A3C;
    endfunction

    // 1-cycle synchronous read memory.
    always @(posedge clk) mem_rdata <= mem_hash(mem_addr);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ena = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_age;     // cycles since grant: 0 none, 1 on memory bus, 2 acking
    bit          m_data;
    logic [29:0] m_addr;
    bit          m_we;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    int          m_streak;  // data grants seen while a fetch waited

    task automatic model_step();
        bit want_i, want_d, take_i;
        if (m_age == 1) begin
            m_age = 2;
        end else begin
            want_i = if_req && !(m_age == 2 && !m_data);
            want_d = d_req  && !(m_age == 2 &&  m_data);
            if (ena && (want_i || want_d)) begin
                take_i = want_i && (!want_d || m_streak == LIMIT);
                if (take_i) begin
                    m_streak = 0; m_data = 0; m_addr = if_addr[31:2];
                    m_we = 0; m_be = 4'hF; m_wdata = '0;
                end else begin
                    if (want_i && m_streak < LIMIT) m_streak++;
                    m_data = 1; m_addr = d_addr[31:2]; m_we = d_we;
                    m_be = d_we ? d_be : 4'hF; m_wdata = d_wdata;
                end
                m_age = 1;
            end else begin
                m_age = 0;
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          is_data;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [29:0] exp_maddr;
        logic [3:0]  exp_be;
        bit          exp_we;
        logic [31:0] exp_wdata;
        bit          exp_rd;    // ack carries read data
    } vec_t;

    vec_t vecs[5];

    bit if_rel, d_rel;
    bit e_acc, e_resp;

    task automatic new_fetch();
        if_req = 1'b1; if_addr = $urandom;
    endtask

    task automatic new_data();
        d_req = 1'b1; d_we = $urandom_range(1); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = d_we ? $urandom : 32'h0;
    endtask

    initial begin
        vecs[0] = '{0, 0, 4'h0, 32'h0000_0040, 32'h0,         30'h10,        4'hF, 0, 32'h0,         1};
        vecs[1] = '{1, 0, 4'h2, 32'h0000_0103, 32'h0,         30'h40,        4'hF, 0, 32'h0,         1};
        vecs[2] = '{1, 1, 4'h3, 32'h0000_0200, 32'hDEAD_BEEF, 30'h80,        4'h3, 1, 32'hDEAD_BEEF, 0};
        vecs[3] = '{0, 0, 4'h0, 32'hFFFF_FFFF, 32'h0,         30'h3FFF_FFFF, 4'hF, 0, 32'h0,         1};
        vecs[4] = '{1, 1, 4'h8, 32'h0000_0007, 32'h1234_5678, 30'h1,         4'h8, 1, 32'h1234_5678, 0};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        idle_inputs();
        #2;
        check("rst_busy", busy, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_acks", {if_ack, d_ack}, 0);
        check("rst_rdata", if_rdata | d_rdata, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();
        check("post_rst_idle", busy, 0);

        // ---------------- table: single transactions from IDLE ----------------
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].is_data) begin
                d_req = 1; d_we = vecs[i].we; d_be = vecs[i].be;
                d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
            end else begin
                if_req = 1; if_addr = vecs[i].addr;
            end
            tick();
            check($sformatf("v%0d_busy", i), busy, 1);
            check($sformatf("v%0d_maddr", i), mem_addr, vecs[i].exp_maddr);
            check($sformatf("v%0d_mbe", i), mem_be, vecs[i].exp_be);
            check($sformatf("v%0d_mwe", i), mem_we, vecs[i].exp_we);
            check($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].exp_wdata);
            check($sformatf("v%0d_no_early_ack", i), {if_ack, d_ack}, 0);
            tick();
            check($sformatf("v%0d_ack", i), {if_ack, d_ack},
                  vecs[i].is_data ? 2'b01 : 2'b10);
            check($sformatf("v%0d_rdata", i), vecs[i].is_data ? d_rdata : if_rdata,
                  vecs[i].exp_rd ? mem_hash(vecs[i].exp_maddr) : 32'h0);
            check($sformatf("v%0d_resp_mwe", i), mem_we, 0);
            check($sformatf("v%0d_resp_maddr", i), mem_addr, 0);
            idle_inputs();
            tick();
            check($sformatf("v%0d_back_idle", i), busy, 0);
        end

        // ---------------- simultaneous requests ----------------
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h100;
        tick();
        check("sim_data_first", mem_addr, 30'h40);
        tick();
        check("sim_d_ack", {if_ack, d_ack}, 2'b01);
        check("sim_d_rdata", d_rdata, mem_hash(30'h40));
        tick();  // d_req still high here: must not be re-granted
        check("sim_fetch_next", mem_addr, 30'h10);
        check("sim_no_gap_busy", busy, 1);
        d_req = 0;
        tick();
        check("sim_if_ack", {if_ack, d_ack}, 2'b10);
        check("sim_if_rdata", if_rdata, mem_hash(30'h10));
        idle_inputs();
        tick();
        check("sim_idle", busy, 0);

        // ---------------- starvation ----------------
        // Enable drops at each data ack so data keeps winning from IDLE while
        // the fetch waits; the counter then forces the fetch through.
        if_req = 1; if_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h200;
        for (int k = 0; k < LIMIT; k++) begin
            tick();
            check($sformatf("starve_data_grant%0d", k), mem_addr, 30'h80);
            ena = 0;
            tick();
            check($sformatf("starve_d_ack%0d", k), {if_ack, d_ack}, 2'b01);
            tick();
            check($sformatf("starve_idle%0d", k), busy, 0);
            ena = 1;
        end
        tick();
        check("starve_fetch_wins", mem_addr, 30'h20);
        tick();
        check("starve_if_ack", {if_ack, d_ack}, 2'b10);
        tick();
        check("starve_data_resumes", mem_addr, 30'h80);
        if_req = 0;
        tick();
        check("starve_resume_ack", {if_ack, d_ack}, 2'b01);
        idle_inputs();
        tick();
        check("starve_idle_end", busy, 0);

        // ---------------- ena dropped during ACCESS ----------------
        if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 1; d_be = 4'hF;
        d_addr = 32'h300; d_wdata = 32'hCAFE_F00D;
        tick();
        check("ena_access", mem_addr, 30'hC0);
        ena = 0;
        tick();
        check("ena_inflight_ack", {if_ack, d_ack}, 2'b01);
        d_req = 0;
        tick();
        check("ena_no_grant", busy, 0);
        tick();
        check("ena_still_idle", {busy, if_ack}, 0);
        ena = 1;
        tick();
        check("ena_resume", mem_addr, 30'h11);
        tick();
        check("ena_resume_ack", if_ack, 1);
        idle_inputs();
        tick();

        // ---------------- reset during ACCESS ----------------
        if_req = 1; if_addr = 32'h40;
        tick();
        check("rstacc_pre", mem_addr, 30'h10);
        rst_n = 0;
        #1;
        check("rstacc_busy", busy, 0);
        check("rstacc_mem", {mem_addr, mem_we, mem_be}, 0);
        check("rstacc_mwdata", mem_wdata, 0);
        check("rstacc_acks", {if_ack, d_ack}, 0);
        if_req = 0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rstacc_never_ack%0d", k), {busy, if_ack, d_ack}, 0);
        end

        // ---------------- random vs reference model ----------------
        m_age = 0; m_streak = 0; m_data = 0; m_addr = '0;
        m_we = 0; m_be = '0; m_wdata = '0;
        if_rel = 0; d_rel = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            model_step();
            e_acc  = (m_age == 1);
            e_resp = (m_age == 2);
            check("rnd_busy", busy, e_acc || e_resp);
            check("rnd_mem_addr", mem_addr, e_acc ? m_addr : 30'h0);
            check("rnd_mem_we", mem_we, e_acc && m_we);
            check("rnd_mem_be", mem_be, e_acc ? m_be : 4'h0);
            check("rnd_mem_wdata", mem_wdata, e_acc ? m_wdata : 32'h0);
            check("rnd_if_ack", if_ack, e_resp && !m_data);
            check("rnd_d_ack", d_ack, e_resp && m_data);
            check("rnd_if_rdata", if_rdata, (e_resp && !m_data) ? mem_hash(m_addr) : 32'h0);
            check("rnd_d_rdata", d_rdata,
                  (e_resp && m_data && !m_we) ? mem_hash(m_addr) : 32'h0);

            // Requesters: hold req through the ack cycle, then drop or re-issue.
            if (if_rel) begin
                if_rel = 0;
                if ($urandom_range(1) == 1) new_fetch(); else if_req = 0;
            end else if (!if_req && $urandom_range(3) == 0) begin
                new_fetch();
            end else if (if_req && $urandom_range(3) == 0) begin
                if_addr = $urandom;  // in-flight captures must not follow this
            end
            if (d_rel) begin
                d_rel = 0;
                if ($urandom_range(1) == 1) new_data(); else d_req = 0;
            end else if (!d_req && $urandom_range(2) == 0) begin
                new_data();
            end else if (d_req && $urandom_range(3) == 0) begin
                d_addr = $urandom; d_be = 4'($urandom);
            end
            if (e_resp && !m_data) if_rel = 1;
            if (e_resp &&  m_data) d_rel = 1;
            ena = ($urandom_range(7) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
